// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined shifter.
// Holds the operation encoding and the default datapath/tag widths used by
// pipe_shifter and its per-level stage slices.
package shifter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_TAG_W = 5;

  // Codes 5..7 are not named: they carry the operand through unchanged.
  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } shift_op_e;

endpackage

// File: rtl/shift_stage.sv
// One level of the logarithmic shifter pipeline.
// Applies a 2^K shift/rotate when shamt bit K is set, then registers the
// result together with valid, op, the not-yet-consumed shamt bits and tag.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_flush          clear the valid bit on the next edge (wins over load)
//   i_load           this slice may capture its upstream inputs
//   i_valid/i_data/i_op/i_shamt/i_tag   upstream slice contents
//   o_valid/o_data/o_op/o_shamt/o_tag   registered slice contents
module shift_stage
  import shifter_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  parameter  int unsigned TAG_W = DEFAULT_TAG_W,
  parameter  int unsigned K     = 0,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  shift_op_e        i_op,
  input  logic [SHW-1:0]   i_shamt,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output shift_op_e        o_op,
  output logic [SHW-1:0]   o_shamt,
  output logic [TAG_W-1:0] o_tag
);

  localparam int unsigned AMT = 1 << K;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  shift_op_e        op_q,    op_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [TAG_W-1:0] tag_q,   tag_d;
  logic [WIDTH-1:0] shifted;

  // An arithmetic shift keeps the MSB, so every level's MSB is still the
  // original operand's sign bit and serves as the fill here.
  always_comb begin
    shifted = i_data;
    if (i_shamt[K]) begin
      case (i_op)
        OP_SLL:  shifted = i_data << AMT;
        OP_SRL:  shifted = i_data >> AMT;
        OP_SRA:  shifted = $signed(i_data) >>> AMT;
        OP_ROL:  shifted = (i_data << AMT) | (i_data >> (WIDTH - AMT));
        OP_ROR:  shifted = (i_data >> AMT) | (i_data << (WIDTH - AMT));
        default: shifted = i_data;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    op_d    = op_q;
    shamt_d = shamt_q;
    tag_d   = tag_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (i_load) begin
      valid_d = i_valid;
      if (i_valid) begin
        data_d     = shifted;
        op_d       = i_op;
        shamt_d    = i_shamt;
        shamt_d[K] = 1'b0;
        tag_d      = i_tag;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      op_q    <= OP_SLL;
      shamt_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      op_q    <= op_d;
      shamt_q <= shamt_d;
      tag_q   <= tag_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_op    = op_q;
  assign o_shamt = shamt_q;
  assign o_tag   = tag_q;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter/rotator with valid/ready handshakes and flush.
// SHW = log2(WIDTH) register stages; stage k handles shamt bit k.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid, o_ready      input handshake (accept on i_valid && o_ready)
//   i_data, i_shamt, i_op, i_tag   operation (op codes in shifter_pkg)
//   i_flush               drop everything in flight on the next edge
//   o_valid, i_ready      output handshake (drain on o_valid && i_ready)
//   o_data, o_tag         result and its tag, held while stalled
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  parameter  int unsigned TAG_W = DEFAULT_TAG_W,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_shamt,
  input  logic [2:0]       i_op,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [TAG_W-1:0] o_tag
);

  // Index 0 is the input port; index k+1 is the register of stage k.
  logic [SHW:0]     vld;
  logic [WIDTH-1:0] data_a  [SHW+1];
  shift_op_e        op_a    [SHW+1];
  logic [SHW-1:0]   shamt_a [SHW+1];
  logic [TAG_W-1:0] tag_a   [SHW+1];

  // rdy[k]: stage k may load this cycle; rdy[SHW] is the downstream ready.
  logic [SHW:0]     rdy;

  assign vld[0]     = i_valid;
  assign data_a[0]  = i_data;
  assign op_a[0]    = shift_op_e'(i_op);
  assign shamt_a[0] = i_shamt;
  assign tag_a[0]   = i_tag;

  // A stage can load when it is empty or its content moves on this cycle;
  // evaluated from the output end back toward the input.
  always_comb begin
    rdy      = '0;
    rdy[SHW] = i_ready;
    for (int unsigned k = SHW; k > 0; k--) begin
      rdy[k-1] = !vld[k] || rdy[k];
    end
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .K     (k)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (i_flush),
      .i_load  (rdy[k]),
      .i_valid (vld[k]),
      .i_data  (data_a[k]),
      .i_op    (op_a[k]),
      .i_shamt (shamt_a[k]),
      .i_tag   (tag_a[k]),
      .o_valid (vld[k+1]),
      .o_data  (data_a[k+1]),
      .o_op    (op_a[k+1]),
      .o_shamt (shamt_a[k+1]),
      .o_tag   (tag_a[k+1])
    );
  end

  assign o_ready = rdy[0];
  assign o_valid = vld[SHW];
  assign o_data  = data_a[SHW];
  assign o_tag   = tag_a[SHW];

  // Op and shamt are fully consumed once the last level has been applied.
  logic unused_tail;
  assign unused_tail = ^{op_a[SHW], shamt_a[SHW]};

endmodule

// File: tb/tb_pipe_shifter.sv
module tb_pipe_shifter;

  localparam int W   = 32;
  localparam int TW  = 5;
  localparam int LAT = 5;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [W-1:0]  i_data = '0;
  logic [4:0]    i_shamt = '0;
  logic [2:0]    i_op = '0;
  logic [TW-1:0] i_tag = '0;
  logic          i_flush = 1'b0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [W-1:0]  o_data;
  logic [TW-1:0] o_tag;

  pipe_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_shamt (i_shamt),
    .i_op    (i_op),
    .i_tag   (i_tag),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_tag   (o_tag)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    int            acc;
    bit            chk;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference: whole-amount shift/rotate in one step.
  function automatic logic [W-1:0] ref_model(input logic [2:0] op,
                                             input logic [W-1:0] d,
                                             input logic [4:0] s);
    logic [2*W-1:0] dd;
    int unsigned n;
    n  = s;
    dd = {d, d};
    case (op)
      3'd0: return d << n;
      3'd1: return d >> n;
      3'd2: return $signed(d) >>> n;
      3'd3: begin dd = dd << n; return dd[2*W-1:W]; end
      3'd4: begin dd = dd >> n; return dd[W-1:0]; end
      default: return d;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    bit hold = 1'b0;
    logic [W-1:0] hd;
    logic [TW-1:0] ht;
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold && o_valid) chk("hold_stable", 64'({o_data, o_tag}), 64'({hd, ht}));
        if (o_valid && i_ready && !i_flush) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got data %h tag %0d, required no output", o_data, o_tag);
          end else begin
            e = sb.pop_front();
            chk("result_data", 64'(o_data), 64'(e.data));
            chk("result_tag", 64'(o_tag), 64'(e.tag));
            if (e.chk) chk("latency", 64'(cyc - e.acc + 1), 64'(LAT));
          end
        end
        hold = o_valid && !i_ready && !i_flush;
        hd   = o_data;
        ht   = o_tag;
      end
    end
  endtask

  // Offer one op starting at posedge+1; returns at posedge+1 after acceptance.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] d, input logic [4:0] s,
                       input logic [TW-1:0] t, input bit chk_lat, input bit rnd_rdy);
    bit accepted = 1'b0;
    i_valid = 1'b1;
    i_op    = op;
    i_data  = d;
    i_shamt = s;
    i_tag   = t;
    for (int w = 0; w < 64; w++) begin
      @(negedge i_clk);
      if (o_ready) begin
        sb.push_back('{ref_model(op, d, s), t, cyc + 1, chk_lat});
        accepted = 1'b1;
        break;
      end
      @(posedge i_clk); #1;
      if (rnd_rdy) i_ready = ($urandom_range(0, 3) != 0);
    end
    if (!accepted) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no o_ready in 64 cycles, required acceptance (tag %0d)", t);
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    if (rnd_rdy) i_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain();
    bit done = 1'b0;
    i_ready = 1'b1;
    for (int w = 0; w < 64; w++) begin
      @(negedge i_clk);
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb.size());
    end
    @(posedge i_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_valid", 64'(o_valid), 64'(0));
    chk("reset_data", 64'(o_data), 64'(0));
    chk("reset_tag", 64'(o_tag), 64'(0));
    chk("reset_ready", 64'(o_ready), 64'(1));
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // SRA sign fill through every level, exact latency
    i_ready = 1'b1;
    issue(3'd2, 32'h8000_0000, 5'd31, 5'd3, 1'b1, 1'b0);
    drain();

    // Back-to-back stream
    issue(3'd4, 32'h0000_0001, 5'd1, 5'd1, 1'b1, 1'b0);
    issue(3'd3, 32'h8000_0000, 5'd1, 5'd2, 1'b1, 1'b0);
    issue(3'd0, 32'h0000_FFFF, 5'd16, 5'd4, 1'b1, 1'b0);
    issue(3'd1, 32'hF000_0000, 5'd28, 5'd5, 1'b1, 1'b0);
    drain();

    // Pass-through code and zero shift amount for every op
    issue(3'd7, 32'h1234_5678, 5'd13, 5'd7, 1'b1, 1'b0);
    for (int op = 0; op < 8; op++)
      issue(3'(op), $urandom, 5'd0, 5'(10 + op), 1'b1, 1'b0);
    drain();

    // Backpressure: five fill the pipe, the sixth waits
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      issue(3'(k), 32'hC3A5_0F01 + 32'(k), 5'(3 * k + 1), 5'(k), 1'b0, 1'b0);
    i_valid = 1'b1;
    i_op    = 3'd2;
    i_data  = 32'h9000_0001;
    i_shamt = 5'd7;
    i_tag   = 5'd5;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk("full_o_ready", 64'(o_ready), 64'(0));
      chk("full_o_valid", 64'(o_valid), 64'(1));
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    issue(3'd2, 32'h9000_0001, 5'd7, 5'd5, 1'b0, 1'b0);
    drain();

    // Flush with three in flight and a fourth offered
    issue(3'd0, 32'h0000_0011, 5'd1, 5'd20, 1'b0, 1'b0);
    issue(3'd1, 32'h0000_1100, 5'd2, 5'd21, 1'b0, 1'b0);
    issue(3'd3, 32'h0011_0000, 5'd3, 5'd22, 1'b0, 1'b0);
    i_valid = 1'b1;
    i_op    = 3'd4;
    i_data  = 32'h1100_0000;
    i_shamt = 5'd4;
    i_tag   = 5'd23;
    i_flush = 1'b1;
    @(negedge i_clk);
    sb.delete();
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      chk("flush_o_valid", 64'(o_valid), 64'(0));
    end
    @(posedge i_clk); #1;

    // Asynchronous reset mid-stream
    for (int k = 0; k < 6; k++)
      issue(3'd7, 32'hA5A5_0000 | 32'(k + 1), 5'd0, 5'(24 + k), 1'b0, 1'b0);
    #2;
    chk("pre_reset_valid", 64'(o_valid), 64'(1));
    i_rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(o_valid), 64'(0));
    chk("async_reset_data", 64'(o_data), 64'(0));
    chk("async_reset_tag", 64'(o_tag), 64'(0));
    chk("async_reset_ready", 64'(o_ready), 64'(1));
    sb.delete();
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_hold_valid", 64'(o_valid), 64'(0));
    chk("reset_hold_data", 64'(o_data), 64'(0));
    #2;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    issue(3'd0, 32'h0000_0001, 5'd4, 5'd9, 1'b1, 1'b0);
    drain();

    // Random traffic with random backpressure and occasional flushes
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        i_flush = 1'b1;
        @(negedge i_clk);
        sb.delete();
        @(posedge i_clk); #1;
        i_flush = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) begin
        @(posedge i_clk); #1;
        i_ready = ($urandom_range(0, 3) != 0);
      end
      issue(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 1'b0, 1'b1);
    end
    drain();

    // Random traffic at full rate with latency checking
    i_ready = 1'b1;
    for (int n = 0; n < 40; n++)
      issue(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 1'b1, 1'b0);
    drain();

    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("idle_o_valid", 64'(o_valid), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
